// File: rtl/uart_sched_pkg.sv
// Shared types for the UART transfer scheduler.
// Contents: FSM state encoding, transmitter grant identifiers, timer width,
// and timer helpers (terminal-count value and saturating increment).
package uart_sched_pkg;

    localparam int unsigned TMR_W = 16;

    typedef logic [TMR_W-1:0] tmr_t;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StRdPulse = 3'd1,
        StRdWait  = 3'd2,
        StTxSetup = 3'd3,
        StTxLock  = 3'd4,
        StTxWait  = 3'd5
    } state_e;

    typedef enum logic {
        GNT_ECHO = 1'b0,
        GNT_HOST = 1'b1
    } gnt_e;

    // Timer value on the last cycle of an N-cycle phase (timers count 0..N-1).
    function automatic tmr_t tmr_last(input int unsigned n);
        return tmr_t'(n - 1);
    endfunction

    function automatic tmr_t tmr_inc(input tmr_t t);
        return (t == '1) ? t : t + tmr_t'(1);
    endfunction

endpackage

// File: rtl/sched_rr_arb2.sv
// Two-requester round-robin arbiter for the UART transmitter.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   req_echo_i        echo hold register has a byte pending
//   req_host_i        host byte request
//   adv_i             current grant is being taken; advance the pointer
//   gnt_vld_o         at least one requester is pending
//   gnt_o             which requester wins this cycle
module sched_rr_arb2
    import uart_sched_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_echo_i,
    input  logic req_host_i,
    input  logic adv_i,
    output logic gnt_vld_o,
    output gnt_e gnt_o
);

    gnt_e ptr_q, ptr_d;

    always_comb begin
        gnt_vld_o = req_echo_i | req_host_i;
        if (req_echo_i && req_host_i) begin
            gnt_o = ptr_q;
        end else if (req_echo_i) begin
            gnt_o = GNT_ECHO;
        end else begin
            gnt_o = GNT_HOST;
        end
    end

    // Pointer moves to the other requester after every grant, contested or not.
    always_comb begin
        ptr_d = ptr_q;
        if (adv_i && gnt_vld_o) begin
            ptr_d = (gnt_o == GNT_ECHO) ? GNT_HOST : GNT_ECHO;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= GNT_ECHO;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/uart_xfer_sched.sv
// Sequencing controller for the UART core: drains RX bytes with the RDEN
// strobe, loads TX bytes through TDR/LOCK_TDR, and arbitrates the transmitter
// between the RX echo path and a host requester.
// Ports:
//   CLK, RST                 clock, asynchronous active-high reset
//   ECHO_EN                  queue received bytes for retransmission
//   RX_SR, RD_CNT, RDR       core receive status, unread count, data
//   TC                       core transmit complete
//   RDEN, LOCK_TDR, TDR      core read strobe, TDR latch strobe, TX data
//   HOST_VLD/DATA/RDY        host byte request handshake
//   RX_VLD, RX_DATA          received byte output (one-cycle pulse)
//   BUSY, ERR                FSM not idle, sticky TC timeout
module uart_xfer_sched
    import uart_sched_pkg::*;
#(
    parameter int unsigned RD_PULSE_CYC = 4,
    parameter int unsigned RD_LAT_CYC   = 4,
    parameter int unsigned SETUP_CYC    = 2,
    parameter int unsigned LOCK_CYC     = 4,
    parameter int unsigned TC_GUARD_CYC = 8,
    parameter int unsigned TC_TIMEOUT   = 65535
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       ECHO_EN,
    input  logic       RX_SR,
    input  logic [3:0] RD_CNT,
    input  logic [7:0] RDR,
    input  logic       TC,
    output logic       RDEN,
    output logic       LOCK_TDR,
    output logic [7:0] TDR,
    input  logic       HOST_VLD,
    input  logic [7:0] HOST_DATA,
    output logic       HOST_RDY,
    output logic       RX_VLD,
    output logic [7:0] RX_DATA,
    output logic       BUSY,
    output logic       ERR
);

    state_e     state_q, state_d;
    tmr_t       tmr_q, tmr_d;
    logic       guard_done_q, guard_done_d;
    logic       hold_vld_q, hold_vld_d;
    logic [7:0] hold_data_q, hold_data_d;
    logic       rden_q, rden_d;
    logic       lock_q, lock_d;
    logic [7:0] tdr_q, tdr_d;
    logic       host_rdy_q, host_rdy_d;
    logic       rx_vld_q, rx_vld_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       busy_q, busy_d;
    logic       err_q, err_d;

    logic hold_eff;
    logic arb_adv;
    logic gnt_vld;
    gnt_e gnt;

    // A held byte with echo disabled is discarded this cycle, so it neither
    // blocks reads nor competes for the transmitter.
    assign hold_eff = hold_vld_q & ECHO_EN;

    sched_rr_arb2 u_arb (
        .clk        (CLK),
        .rst        (RST),
        .req_echo_i (hold_eff),
        .req_host_i (HOST_VLD),
        .adv_i      (arb_adv),
        .gnt_vld_o  (gnt_vld),
        .gnt_o      (gnt)
    );

    always_comb begin
        state_d      = state_q;
        tmr_d        = tmr_inc(tmr_q);
        guard_done_d = guard_done_q;
        hold_vld_d   = hold_vld_q;
        hold_data_d  = hold_data_q;
        rden_d       = 1'b0;
        lock_d       = 1'b0;
        tdr_d        = tdr_q;
        host_rdy_d   = 1'b0;
        rx_vld_d     = 1'b0;
        rx_data_d    = rx_data_q;
        err_d        = err_q;
        arb_adv      = 1'b0;

        unique case (state_q)
            StIdle: begin
                tmr_d = '0;
                if (!ECHO_EN && hold_vld_q) begin
                    hold_vld_d = 1'b0;
                end
                if (RX_SR && (RD_CNT != 4'd0) && !hold_eff) begin
                    state_d = StRdPulse;
                    rden_d  = 1'b1;
                end else if (gnt_vld) begin
                    arb_adv = 1'b1;
                    state_d = StTxSetup;
                    if (gnt == GNT_HOST) begin
                        tdr_d      = HOST_DATA;
                        host_rdy_d = 1'b1;
                    end else begin
                        tdr_d      = hold_data_q;
                        hold_vld_d = 1'b0;
                    end
                end
            end
            StRdPulse: begin
                if (tmr_q == tmr_last(RD_PULSE_CYC)) begin
                    state_d = StRdWait;
                    tmr_d   = '0;
                end else begin
                    rden_d = 1'b1;
                end
            end
            StRdWait: begin
                if (tmr_q == tmr_last(RD_LAT_CYC)) begin
                    rx_data_d = RDR;
                    rx_vld_d  = 1'b1;
                    if (ECHO_EN) begin
                        hold_vld_d  = 1'b1;
                        hold_data_d = RDR;
                    end
                    state_d = StIdle;
                end
            end
            StTxSetup: begin
                if (tmr_q == tmr_last(SETUP_CYC)) begin
                    state_d = StTxLock;
                    tmr_d   = '0;
                    lock_d  = 1'b1;
                end
            end
            StTxLock: begin
                if (tmr_q == tmr_last(LOCK_CYC)) begin
                    state_d      = StTxWait;
                    tmr_d        = '0;
                    guard_done_d = 1'b0;
                end else begin
                    lock_d = 1'b1;
                end
            end
            StTxWait: begin
                // Guard phase ignores TC; the timeout timer restarts after it.
                if (!guard_done_q) begin
                    if (tmr_q == tmr_last(TC_GUARD_CYC)) begin
                        guard_done_d = 1'b1;
                        tmr_d        = '0;
                    end
                end else if (TC) begin
                    state_d = StIdle;
                end else if (tmr_q == tmr_last(TC_TIMEOUT)) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= StIdle;
            tmr_q        <= '0;
            guard_done_q <= 1'b0;
            hold_vld_q   <= 1'b0;
            hold_data_q  <= '0;
            rden_q       <= 1'b0;
            lock_q       <= 1'b0;
            tdr_q        <= '0;
            host_rdy_q   <= 1'b0;
            rx_vld_q     <= 1'b0;
            rx_data_q    <= '0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            tmr_q        <= tmr_d;
            guard_done_q <= guard_done_d;
            hold_vld_q   <= hold_vld_d;
            hold_data_q  <= hold_data_d;
            rden_q       <= rden_d;
            lock_q       <= lock_d;
            tdr_q        <= tdr_d;
            host_rdy_q   <= host_rdy_d;
            rx_vld_q     <= rx_vld_d;
            rx_data_q    <= rx_data_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
        end
    end

    assign RDEN     = rden_q;
    assign LOCK_TDR = lock_q;
    assign TDR      = tdr_q;
    assign HOST_RDY = host_rdy_q;
    assign RX_VLD   = rx_vld_q;
    assign RX_DATA  = rx_data_q;
    assign BUSY     = busy_q;
    assign ERR      = err_q;

endmodule

// File: tb/tb_uart_xfer_sched.sv
module tb_uart_xfer_sched;

    localparam int unsigned TC_TO = 1000;
    localparam int unsigned GUARD = 8;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       ECHO_EN = 1'b0;
    logic       RX_SR;
    logic [3:0] RD_CNT;
    logic [7:0] RDR;
    logic       TC = 1'b0;
    logic       RDEN, LOCK_TDR, HOST_RDY, RX_VLD, BUSY, ERR;
    logic [7:0] TDR, RX_DATA;
    logic       HOST_VLD = 1'b0;
    logic [7:0] HOST_DATA = 8'h00;

    always #5 CLK = ~CLK;

    uart_xfer_sched #(.TC_TIMEOUT(TC_TO)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .ECHO_EN   (ECHO_EN),
        .RX_SR     (RX_SR),
        .RD_CNT    (RD_CNT),
        .RDR       (RDR),
        .TC        (TC),
        .RDEN      (RDEN),
        .LOCK_TDR  (LOCK_TDR),
        .TDR       (TDR),
        .HOST_VLD  (HOST_VLD),
        .HOST_DATA (HOST_DATA),
        .HOST_RDY  (HOST_RDY),
        .RX_VLD    (RX_VLD),
        .RX_DATA   (RX_DATA),
        .BUSY      (BUSY),
        .ERR       (ERR)
    );

    int tests_run = 0;
    int tests_failed = 0;

    // Core RX model: bytes made available by the tests, consumed on RDEN rise.
    logic [7:0] rx_bytes [256];
    int         rx_total = 0;
    int         rd_idx = 0;
    logic [7:0] rdr_reg = 8'h00;

    assign RD_CNT = 4'(rx_total - rd_idx);
    assign RX_SR  = (rx_total != rd_idx);
    assign RDR    = rdr_reg;

    logic [7:0] exp_tx [$];
    logic [7:0] exp_rx [$];

    // Monitor state (written only by the monitor).
    int         cyc = 0;
    logic       rden_prev = 1'b0, lock_prev = 1'b0, err_prev = 1'b0;
    logic [7:0] tdr_p1 = 8'h00, tdr_p2 = 8'h00;
    logic [7:0] obs_tx [64];
    logic [7:0] obs_tx_s2 [64];
    int         obs_tx_t [64];
    int         obs_tx_n = 0;
    logic [7:0] obs_rx [64];
    int         obs_rx_t [64];
    int         obs_rx_n = 0;
    int         rden_rise_t [64];
    int         rden_fall_t [64];
    int         rden_n = 0, rden_fn = 0;
    int         lock_fall_t [64];
    int         lock_fn = 0;
    int         host_rdy_n = 0;
    int         err_rise_t = 0, err_n = 0;
    int         overlap_n = 0, tdr_glitch_n = 0;

    always @(negedge CLK) begin
        cyc       <= cyc + 1;
        rden_prev <= RDEN;
        lock_prev <= LOCK_TDR;
        err_prev  <= ERR;
        tdr_p1    <= TDR;
        tdr_p2    <= tdr_p1;
        if (RDEN && !rden_prev) begin
            rdr_reg                    <= rx_bytes[rd_idx[7:0]];
            rd_idx                     <= rd_idx + 1;
            rden_rise_t[rden_n[5:0]]   <= cyc;
            rden_n                     <= rden_n + 1;
        end
        if (!RDEN && rden_prev) begin
            rden_fall_t[rden_fn[5:0]] <= cyc;
            rden_fn                   <= rden_fn + 1;
        end
        if (LOCK_TDR && !lock_prev) begin
            obs_tx[obs_tx_n[5:0]]    <= TDR;
            obs_tx_s2[obs_tx_n[5:0]] <= tdr_p2;
            obs_tx_t[obs_tx_n[5:0]]  <= cyc;
            obs_tx_n                 <= obs_tx_n + 1;
        end
        if (!LOCK_TDR && lock_prev) begin
            lock_fall_t[lock_fn[5:0]] <= cyc;
            lock_fn                   <= lock_fn + 1;
        end
        if (LOCK_TDR && lock_prev && (TDR !== tdr_p1)) tdr_glitch_n <= tdr_glitch_n + 1;
        if (RX_VLD) begin
            obs_rx[obs_rx_n[5:0]]   <= RX_DATA;
            obs_rx_t[obs_rx_n[5:0]] <= cyc;
            obs_rx_n                <= obs_rx_n + 1;
        end
        if (HOST_RDY) host_rdy_n <= host_rdy_n + 1;
        if (ERR && !err_prev) begin
            err_rise_t <= cyc;
            err_n      <= err_n + 1;
        end
        if (RDEN && LOCK_TDR) overlap_n <= overlap_n + 1;
    end

    task automatic push_rx(input logic [7:0] b);
        rx_bytes[rx_total[7:0]] = b;
        rx_total = rx_total + 1;
    endtask

    task automatic do_reset;
        RST = 1'b1;
        HOST_VLD = 1'b0;
        TC = 1'b0;
        ECHO_EN = 1'b0;
        rx_total = rd_idx;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        int t;
        int rd0, tx0;
        #1 RST = 1'b1;
        #2;
        tests_run++;
        if ({RDEN, LOCK_TDR, TDR, HOST_RDY, RX_VLD, RX_DATA, BUSY, ERR} !== 20'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %h want 0",
                     {RDEN, LOCK_TDR, TDR, HOST_RDY, RX_VLD, RX_DATA, BUSY, ERR});
        end
        do_reset();
        tx0 = obs_tx_n;
        HOST_DATA = 8'h77;
        HOST_VLD = 1'b1;
        t = 0;
        while (!LOCK_TDR && t < 50) begin
            @(posedge CLK); #1;
            if (HOST_RDY) HOST_VLD = 1'b0;
            t++;
        end
        tests_run++;
        if (LOCK_TDR !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_reach_lock: got %b want 1", LOCK_TDR);
        end
        @(posedge CLK);
        #2 RST = 1'b1;
        #1;
        tests_run++;
        if ({LOCK_TDR, BUSY, ERR} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_mid_lock: got lock/busy/err %b want 000", {LOCK_TDR, BUSY, ERR});
        end
        rd0 = rden_n;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        repeat (20) @(posedge CLK);
        #1;
        tests_run++;
        if (rden_n !== rd0 || BUSY !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release_idle: got rden %0d busy %b want %0d 0",
                     rden_n - rd0, BUSY, 0);
        end
        tests_run++;
        if (obs_tx_n !== tx0 + 1) begin
            tests_failed++;
            $display("FAIL reset_no_resend: got %0d locks want 1", obs_tx_n - tx0);
        end
    endtask

    task automatic test_echo;
        int t, rx0, tx0, rd0, lf0;
        do_reset();
        rx0 = obs_rx_n; tx0 = obs_tx_n; rd0 = rden_n; lf0 = lock_fn;
        ECHO_EN = 1'b1;
        exp_rx.push_back(8'h5A);
        exp_tx.push_back(8'h5A);
        push_rx(8'h5A);
        t = 0;
        while (lock_fn == lf0 && t < 100) begin
            @(posedge CLK); #1;
            t++;
        end
        tests_run++;
        if (lock_fn !== lf0 + 1) begin
            tests_failed++;
            $display("FAIL echo_lock_seen: got %0d want 1", lock_fn - lf0);
        end
        tests_run++;
        if (rden_fall_t[rd0[5:0]] - rden_rise_t[rd0[5:0]] !== 4) begin
            tests_failed++;
            $display("FAIL echo_rden_width: got %0d want 4",
                     rden_fall_t[rd0[5:0]] - rden_rise_t[rd0[5:0]]);
        end
        tests_run++;
        if (obs_rx_t[rx0[5:0]] - rden_fall_t[rd0[5:0]] !== 4) begin
            tests_failed++;
            $display("FAIL echo_rx_latency: got %0d want 4",
                     obs_rx_t[rx0[5:0]] - rden_fall_t[rd0[5:0]]);
        end
        tests_run++;
        if (obs_rx[rx0[5:0]] !== exp_rx[0]) begin
            tests_failed++;
            $display("FAIL echo_rx_data: got %h want %h", obs_rx[rx0[5:0]], exp_rx[0]);
        end
        void'(exp_rx.pop_front());
        tests_run++;
        if (obs_tx_t[tx0[5:0]] - obs_rx_t[rx0[5:0]] !== 3) begin
            tests_failed++;
            $display("FAIL echo_lock_start: got %0d want 3",
                     obs_tx_t[tx0[5:0]] - obs_rx_t[rx0[5:0]]);
        end
        tests_run++;
        if (obs_tx[tx0[5:0]] !== exp_tx[0] || obs_tx_s2[tx0[5:0]] !== exp_tx[0]) begin
            tests_failed++;
            $display("FAIL echo_tdr: got %h (setup %h) want %h",
                     obs_tx[tx0[5:0]], obs_tx_s2[tx0[5:0]], exp_tx[0]);
        end
        void'(exp_tx.pop_front());
        tests_run++;
        if (lock_fall_t[lf0[5:0]] - obs_tx_t[tx0[5:0]] !== 4) begin
            tests_failed++;
            $display("FAIL echo_lock_width: got %0d want 4",
                     lock_fall_t[lf0[5:0]] - obs_tx_t[tx0[5:0]]);
        end
        repeat (12) @(posedge CLK);
        #1;
        tests_run++;
        if (BUSY !== 1'b1) begin
            tests_failed++;
            $display("FAIL echo_waits_tc: got busy %b want 1", BUSY);
        end
        TC = 1'b1;
        @(posedge CLK); #1;
        TC = 1'b0;
        t = 0;
        while (BUSY && t < 5) begin
            @(posedge CLK); #1;
            t++;
        end
        tests_run++;
        if ({BUSY, ERR} !== 2'b00 || rden_n !== rd0 + 1) begin
            tests_failed++;
            $display("FAIL echo_tc_idle: got busy/err %b reads %0d want 00 1",
                     {BUSY, ERR}, rden_n - rd0);
        end
    endtask

    task automatic test_arbitration;
        int t, tx0, hr0, rx0, rdy;
        do_reset();
        tx0 = obs_tx_n; hr0 = host_rdy_n; rx0 = obs_rx_n;
        ECHO_EN = 1'b1;
        TC = 1'b1;
        exp_tx.push_back(8'h11);
        exp_tx.push_back(8'h22);
        exp_tx.push_back(8'h33);
        push_rx(8'h11);
        HOST_DATA = 8'h22;
        HOST_VLD = 1'b1;
        rdy = 0;
        t = 0;
        while (!(obs_tx_n >= tx0 + 3 && !BUSY && !HOST_VLD) && t < 400) begin
            @(posedge CLK); #1;
            if (HOST_RDY) begin
                rdy++;
                if (rdy == 1) HOST_DATA = 8'h33;
                else HOST_VLD = 1'b0;
            end
            t++;
        end
        repeat (5) @(posedge CLK);
        #1;
        tests_run++;
        if (obs_tx_n - tx0 !== 3) begin
            tests_failed++;
            $display("FAIL arb_tx_count: got %0d want 3", obs_tx_n - tx0);
        end
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (obs_tx[(tx0 + i) % 64] !== exp_tx[0]) begin
                tests_failed++;
                $display("FAIL arb_order_%0d: got %h want %h", i, obs_tx[(tx0 + i) % 64], exp_tx[0]);
            end
            void'(exp_tx.pop_front());
        end
        tests_run++;
        if (host_rdy_n - hr0 !== 2) begin
            tests_failed++;
            $display("FAIL arb_host_rdy: got %0d want 2", host_rdy_n - hr0);
        end
        tests_run++;
        if (obs_rx_n - rx0 !== 1 || obs_rx[rx0[5:0]] !== 8'h11) begin
            tests_failed++;
            $display("FAIL arb_rx: got %0d bytes first %h want 1 11",
                     obs_rx_n - rx0, obs_rx[rx0[5:0]]);
        end
    endtask

    task automatic test_drain;
        int t, rx0, tx0, rd0;
        do_reset();
        rx0 = obs_rx_n; tx0 = obs_tx_n; rd0 = rden_n;
        ECHO_EN = 1'b0;
        TC = 1'b1;
        exp_rx.push_back(8'hA1);
        exp_rx.push_back(8'hB2);
        exp_rx.push_back(8'hC3);
        push_rx(8'hA1);
        push_rx(8'hB2);
        push_rx(8'hC3);
        t = 0;
        while (!(obs_rx_n >= rx0 + 3 && !BUSY) && t < 100) begin
            @(posedge CLK); #1;
            t++;
        end
        repeat (20) @(posedge CLK);
        #1;
        tests_run++;
        if (rden_n - rd0 !== 3 || obs_rx_n - rx0 !== 3) begin
            tests_failed++;
            $display("FAIL drain_count: got reads %0d pulses %0d want 3 3",
                     rden_n - rd0, obs_rx_n - rx0);
        end
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (obs_rx[(rx0 + i) % 64] !== exp_rx[0]) begin
                tests_failed++;
                $display("FAIL drain_data_%0d: got %h want %h", i, obs_rx[(rx0 + i) % 64], exp_rx[0]);
            end
            void'(exp_rx.pop_front());
        end
        for (int i = 0; i < 2; i++) begin
            tests_run++;
            if (rden_rise_t[(rd0 + i + 1) % 64] - rden_rise_t[(rd0 + i) % 64] < 9) begin
                tests_failed++;
                $display("FAIL drain_spacing_%0d: got %0d want >=9", i,
                         rden_rise_t[(rd0 + i + 1) % 64] - rden_rise_t[(rd0 + i) % 64]);
            end
        end
        tests_run++;
        if (obs_tx_n !== tx0) begin
            tests_failed++;
            $display("FAIL drain_no_lock: got %0d locks want 0", obs_tx_n - tx0);
        end
    endtask

    task automatic test_timeout;
        int t, tx0, lf0, e0;
        do_reset();
        tx0 = obs_tx_n; lf0 = lock_fn; e0 = err_n;
        TC = 1'b0;
        exp_tx.push_back(8'hA5);
        HOST_DATA = 8'hA5;
        HOST_VLD = 1'b1;
        t = 0;
        while (err_n == e0 && t < int'(GUARD + TC_TO) + 100) begin
            @(posedge CLK); #1;
            if (HOST_RDY) HOST_VLD = 1'b0;
            t++;
        end
        tests_run++;
        if (obs_tx[tx0[5:0]] !== exp_tx[0]) begin
            tests_failed++;
            $display("FAIL timeout_tdr: got %h want %h", obs_tx[tx0[5:0]], exp_tx[0]);
        end
        void'(exp_tx.pop_front());
        tests_run++;
        if (ERR !== 1'b1 || BUSY !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_err: got err/busy %b want 10", {ERR, BUSY});
        end
        tests_run++;
        if (err_rise_t - lock_fall_t[lf0[5:0]] !== int'(GUARD + TC_TO)) begin
            tests_failed++;
            $display("FAIL timeout_delay: got %0d want %0d",
                     err_rise_t - lock_fall_t[lf0[5:0]], GUARD + TC_TO);
        end
        TC = 1'b1;
        exp_tx.push_back(8'h3C);
        HOST_DATA = 8'h3C;
        HOST_VLD = 1'b1;
        t = 0;
        while (!(obs_tx_n >= tx0 + 2 && !BUSY) && t < 100) begin
            @(posedge CLK); #1;
            if (HOST_RDY) HOST_VLD = 1'b0;
            t++;
        end
        tests_run++;
        if (obs_tx[(tx0 + 1) % 64] !== exp_tx[0] || obs_tx_n !== tx0 + 2) begin
            tests_failed++;
            $display("FAIL timeout_next_host: got %h (%0d sends) want %h",
                     obs_tx[(tx0 + 1) % 64], obs_tx_n - tx0, exp_tx[0]);
        end
        void'(exp_tx.pop_front());
        tests_run++;
        if (ERR !== 1'b1) begin
            tests_failed++;
            $display("FAIL timeout_sticky: got %b want 1", ERR);
        end
    endtask

    task automatic test_withdraw;
        int t, tx0, hr0, rx0;
        do_reset();
        tx0 = obs_tx_n; hr0 = host_rdy_n; rx0 = obs_rx_n;
        ECHO_EN = 1'b0;
        TC = 1'b1;
        exp_rx.push_back(8'h6E);
        push_rx(8'h6E);
        HOST_DATA = 8'h99;
        HOST_VLD = 1'b1;
        t = 0;
        while (!RDEN && t < 20) begin
            @(posedge CLK); #1;
            t++;
        end
        repeat (2) @(posedge CLK);
        #1 HOST_VLD = 1'b0;
        repeat (40) @(posedge CLK);
        #1;
        tests_run++;
        if (host_rdy_n !== hr0 || obs_tx_n !== tx0) begin
            tests_failed++;
            $display("FAIL withdraw_no_send: got rdy %0d locks %0d want 0 0",
                     host_rdy_n - hr0, obs_tx_n - tx0);
        end
        tests_run++;
        if (obs_rx_n - rx0 !== 1 || obs_rx[rx0[5:0]] !== exp_rx[0]) begin
            tests_failed++;
            $display("FAIL withdraw_rx: got %0d bytes %h want 1 %h",
                     obs_rx_n - rx0, obs_rx[rx0[5:0]], exp_rx[0]);
        end
        void'(exp_rx.pop_front());
    endtask

    task automatic test_invariants;
        tests_run++;
        if (overlap_n !== 0 || tdr_glitch_n !== 0) begin
            tests_failed++;
            $display("FAIL invariants: got overlap %0d tdr_changes %0d want 0 0",
                     overlap_n, tdr_glitch_n);
        end
    endtask

    initial begin
        test_reset();
        test_echo();
        test_arbitration();
        test_drain();
        test_timeout();
        test_withdraw();
        test_invariants();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_xfer_sched.md
Name: uart_xfer_sched

Overview:
Sequencing controller for the UART_TOP core.
- Drains received bytes through the core's asynchronous RDEN read strobe.
- Loads transmit bytes through the TDR bus and the lockTDR rising-edge latch.
- Arbitrates the transmitter between an RX echo path and a host byte requester.
- Sits between UART_TOP and the top level, replacing free-running strobe logic with a single-clock FSM.

Parameters:
RD_PULSE_CYC, 4, cycles RDEN is held high per read (≥2)
RD_LAT_CYC, 4, cycles after RDEN falls before RDR is sampled
SETUP_CYC, 2, cycles TDR is stable before lockTDR rises
LOCK_CYC, 4, cycles lockTDR is held high (TDR held throughout)
TC_GUARD_CYC, 8, cycles after lockTDR falls before TC is examined
TC_TIMEOUT, 65535, max cycles waiting for TC before error (16-bit timer)

Ports:
CLK  in  1  system clock, 100 MHz domain
RST  in  1  asynchronous, active-high reset
ECHO_EN  in  1  1 = received bytes are queued for retransmission
RX_SR  in  1  UART core: unread RX data present
RD_CNT  in  4  UART core: count of unread RX bytes
RDR  in  8  UART core: receive data register
TC  in  1  UART core: all buffered TX bytes sent
RDEN  out  1  UART core read strobe
LOCK_TDR  out  1  UART core TDR latch strobe
TDR  out  8  UART core transmit data
HOST_VLD  in  1  host byte request; held until HOST_RDY
HOST_DATA  in  8  host byte; stable while HOST_VLD
HOST_RDY  out  1  one-cycle accept pulse
RX_VLD  out  1  one-cycle pulse, RX_DATA valid
RX_DATA  out  8  byte read from core
BUSY  out  1  FSM not in IDLE
ERR  out  1  sticky TC timeout flag

Behaviour:
- Reset (async, RST=1): all outputs 0, FSM=IDLE, echo hold register empty, round-robin pointer = echo, timer 0. RST mid-operation aborts immediately; the partially read or sent byte is lost.
- States: IDLE, RD_PULSE, RD_WAIT, TX_SETUP, TX_LOCK, TX_WAIT.
- IDLE decisions, evaluated in this order every cycle:
  1. If ECHO_EN=0 and the hold register is full, clear the hold register.
  2. If RX_SR=1, RD_CNT≠0 and the hold register is empty, go to RD_PULSE.
  3. Otherwise, if the hold register is full (echo pending) or HOST_VLD=1, grant the transmitter and go to TX_SETUP. When both are pending, grant goes round-robin starting from the pointer; the pointer moves to the other requester after a grant.
- RD_PULSE: RDEN=1 for exactly RD_PULSE_CYC cycles, then RD_WAIT.
- RD_WAIT: RDEN=0 for RD_LAT_CYC cycles. On the last cycle:
  - register RX_DATA<=RDR and pulse RX_VLD for 1 cycle;
  - if ECHO_EN=1, load the hold register;
  - return to IDLE.
  - Minimum spacing between RDEN rising edges is RD_PULSE_CYC+RD_LAT_CYC+1 cycles.
- TX_SETUP, first cycle: TDR<=granted byte. If the host was granted, HOST_RDY=1 for that cycle only; if echo was granted, the hold register is cleared. Stay SETUP_CYC cycles.
- TX_LOCK: LOCK_TDR=1 for LOCK_CYC cycles; TDR unchanged.
- TX_WAIT:
  - LOCK_TDR=0; wait TC_GUARD_CYC cycles, then wait for TC=1 and return to IDLE.
  - If TC stays 0 for TC_TIMEOUT cycles after the guard, set ERR=1 (sticky until RST) and return to IDLE.
  - TDR holds its last value until the next TX_SETUP.
- Reads and transmits never overlap; RDEN and LOCK_TDR are never high together.
- HOST_VLD dropped before HOST_RDY: the request is withdrawn and no byte is sent. HOST_DATA is sampled only in the accept cycle.
- Simultaneous events: an RX-available condition in IDLE takes precedence over a transmit only while the hold register is empty. This keeps the RX FIFO draining while echo is blocked, and guarantees no echo byte is overwritten.
- Timers count from 0 to N−1 using saturating 16-bit arithmetic; parameters are compared with unsigned ==.

Decomposition:
- Shared package uart_sched_pkg: FSM state enum (3-bit encoding), grant enum {GNT_ECHO, GNT_HOST}, timer width constant TMR_W=16.
- One natural sub-module, sched_rr_arb2: two-requester round-robin arbiter with a registered pointer that advances on grant. The FSM, timers and data registers stay in uart_xfer_sched.

Test Plan:
- Reset: RST=1 mid-TX_LOCK → same cycle LOCK_TDR=0, BUSY=0, ERR=0; after release, IDLE with no spurious RDEN.
- Echo: ECHO_EN=1, RX_SR=1, RD_CNT=1, RDR=0x5A →
  - RDEN high exactly 4 cycles;
  - RX_VLD pulse with RX_DATA=0x5A 4 cycles after RDEN falls;
  - TDR=0x5A held 2 cycles, then LOCK_TDR high 4 cycles;
  - TC pulsed → IDLE.
- Arbitration: echo byte 0x11 held, HOST_VLD=1 with 0x22 and 0x33 back-to-back, TC always 1 → send order 0x11, 0x22, 0x33; one HOST_RDY pulse per host byte.
- Drain priority: RD_CNT=3, ECHO_EN=0 → three RDEN pulses spaced ≥9 cycles apart, three RX_VLD pulses, LOCK_TDR never asserted.
- Timeout: host byte 0xA5, TC held 0 → ERR=1 exactly TC_GUARD_CYC+TC_TIMEOUT cycles after LOCK_TDR falls; next HOST_VLD still serviced.
- Withdraw: HOST_VLD asserted then dropped while a read is in progress → no HOST_RDY, no LOCK_TDR.
